seq_input_conditioner: RTL and testbench
========================================

# seq_input_conditioner

Front-end conditioner for the serial sequence detectors: takes a raw slide switch (bit value) and a raw push-button (step) from the board, synchronises and debounces both, and emits one clean bit per button press as a single-cycle `bit_valid` strobe with `bit_out`. The detector FSM downstream advances its state only on `bit_valid`. This replaces free-running divided clocks, so the whole path runs on the board `Clock` with no derived clocks.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in each input synchroniser chain (minimum 2).
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a new level (minimum 2; 10 ms at 100 MHz).
- `Clock`  input  1: board clock; all logic is on the rising edge.
- `Resetn`  input  1: asynchronous, active-low reset.
- `sw_raw`  input  1: raw switch carrying the bit value. Asynchronous and bouncy.
- `btn_raw`  input  1: raw step push-button, active-high. Asynchronous and bouncy.
- `bit_out`  output  1: accepted bit. Holds its value until the next `bit_valid`.
- `bit_valid`  output  1: one-cycle strobe. Marks a new `bit_out` for the consumer.
- `sw_level`  output  1: debounced switch level, for LED display.

## Operation
- Each input passes through a `SYNC_STAGES` flip-flop chain, then through its own debounce filter.
- The debounce filter is a 4-state FSM (`ST_LO`, `WAIT_HI`, `ST_HI`, `WAIT_LO`) plus a counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - `ST_LO` with synced input 1: go to `WAIT_HI` and clear the counter.
  - `WAIT_HI` with input 0: return to `ST_LO` (bounce rejected, no output change).
  - `WAIT_HI` with input 1: increment the counter. When the count reaches `DEBOUNCE_CYCLES-1`, go to `ST_HI`.
  - `ST_HI`, `WAIT_LO`: mirror image of the above.
  - Filter output is 1 in `ST_HI` and `WAIT_LO`, and 0 otherwise.
- Step detection: keep a registered copy of the debounced button.
  - A rising edge of the debounced button produces `bit_valid`=1 for exactly one cycle.
  - On that same edge, `bit_out` loads the debounced switch level.
- Falling edges of the button produce nothing.
- Holding the button produces one pulse only.
- If the switch and the button change on the same cycle, `bit_out` takes the switch level that was debounced at that moment (the old value, because the switch filter is still counting).
- The counter never wraps. It is only cleared on a state entry.

## Timing
- Reset values: `bit_out`=0, `bit_valid`=0, `sw_level`=0, both filters in `ST_LO`, counters 0, synchronisers 0.
- Latency from the first edge that samples a new raw level to the debounced output changing: `SYNC_STAGES + DEBOUNCE_CYCLES` edges.
- `bit_valid` asserts on the following edge, for a total of `SYNC_STAGES + DEBOUNCE_CYCLES + 1`.
- A bounce shorter than `DEBOUNCE_CYCLES` synced cycles causes no output change.
- Minimum spacing between `bit_valid` pulses: `2*DEBOUNCE_CYCLES` cycles (one press plus one release).
- Reset asserted mid-debounce: the count is discarded immediately and no pulse is generated. After release, a button still held high is debounced afresh and yields one pulse.

## Configuration
- `SEQ_DEBOUNCE_EN` defined: both filters are present as described above.
- `SEQ_DEBOUNCE_EN` undefined:
  - Filters are removed and the debounced signal equals the synchroniser output.
  - Latency to `bit_valid` becomes `SYNC_STAGES + 1`.
  - The `DEBOUNCE_CYCLES` parameter is ignored.
  - This mode is intended for simulation and for driving from clean sources.

## Structure
- Shared package `seq_det_pkg`:
  - filter state enum `deb_state_t`;
  - default constants `SEQ_SYNC_STAGES` and `SEQ_DEBOUNCE_CYCLES`;
  - bit encoding constants shared with the detectors.
- Sub-module `debounce_filter` (synchroniser + FSM + counter, parameterised identically), instantiated twice: once for the switch, once for the button. The edge detector and the output register live in the top level.

## Test plan
All scenarios use `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4 with `SEQ_DEBOUNCE_EN` defined.
- Reset check: `Resetn`=0 with both raw inputs held 1 → all outputs 0. Release reset → exactly one `bit_valid`, 7 edges later, with `bit_out`=1.
- Clean press: `sw_raw`=0 stable, then `btn_raw` raised for 20 cycles → one `bit_valid` at edge 7, `bit_out`=0, no second pulse at release.
- Bounce rejection: `btn_raw` toggles 1,0,1,0 (one cycle each) and then stays at 0 → no `bit_valid`, button filter back in `ST_LO`.
- Sequence feed: presses carrying switch values 0,0,1,1 → four `bit_valid` pulses with `bit_out` sequence 0,0,1,1. Each pulse is at least 8 cycles apart.
- Simultaneous change: switch 0→1 on the same cycle as a button press → `bit_out`=0. `sw_level` rises 6 edges after the change.
- Macro off: `SEQ_DEBOUNCE_EN` undefined, single-cycle `btn_raw` pulse → `bit_valid` 3 edges later.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial sequence detector path:
// debounce filter states, default conditioner sizing and bit encodings.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_LO,
        WAIT_HI,
        ST_HI,
        WAIT_LO
    } deb_state_t;

    localparam int SEQ_SYNC_STAGES     = 2;
    localparam int SEQ_DEBOUNCE_CYCLES = 1_000_000;

    localparam logic SEQ_BIT_ZERO = 1'b0;
    localparam logic SEQ_BIT_ONE  = 1'b1;

endpackage

// File: rtl/debounce_filter.sv
// Synchroniser chain followed by a 4-state debounce FSM with a stability counter.
// With SEQ_DEBOUNCE_EN undefined the FSM is removed and the synchroniser drives o_level.
module debounce_filter
    import seq_det_pkg::*;
#(
    parameter int SYNC_STAGES     = SEQ_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SEQ_DEBOUNCE_CYCLES
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic i_raw,
    output logic o_level
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_synced;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef SEQ_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    // The entry edge clears the count, so the last wait edge sees DEBOUNCE_CYCLES-2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_LO;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_LO: begin
                if (w_synced) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!w_synced) begin
                    w_state_nxt = ST_LO;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (!w_synced) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (w_synced) begin
                    w_state_nxt = ST_HI;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_LO;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level = (r_state == ST_HI) || (r_state == WAIT_LO);
`else
    if (DEBOUNCE_CYCLES < 2) begin : g_deb_cycles_ignored
    end

    assign o_level = w_synced;
`endif

endmodule

// File: rtl/seq_input_conditioner.sv
// Switch/button front end: debounces both inputs and emits one bit_valid strobe per press.
// Optional macro: SEQ_DEBOUNCE_EN (undefined = filters bypassed, synchronisers only).
module seq_input_conditioner
    import seq_det_pkg::*;
#(
    parameter int SYNC_STAGES     = SEQ_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SEQ_DEBOUNCE_CYCLES
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic sw_raw,
    input  logic btn_raw,
    output logic bit_out,
    output logic bit_valid,
    output logic sw_level
);

    logic w_sw_deb;
    logic w_btn_deb;
    logic w_step;
    logic r_btn_prev;
    logic r_bit_out;
    logic r_bit_valid;

    debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_filter (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .i_raw   (sw_raw),
        .o_level (w_sw_deb)
    );

    debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_filter (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .i_raw   (btn_raw),
        .o_level (w_btn_deb)
    );

    assign w_step = w_btn_deb & ~r_btn_prev;

    // Only the rising edge of the clean button samples the switch.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_btn_prev  <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_out   <= SEQ_BIT_ZERO;
        end else begin
            r_btn_prev  <= w_btn_deb;
            r_bit_valid <= w_step;
            if (w_step) begin
                r_bit_out <= w_sw_deb;
            end
        end
    end

    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign sw_level  = w_sw_deb;

endmodule

// File: tb/tb_seq_input_conditioner.sv
// Directed bench for seq_input_conditioner with a run-length reference model.
// Works with SEQ_DEBOUNCE_EN defined or undefined.
module tb_seq_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef SEQ_DEBOUNCE_EN
    localparam int LAT           = 7;  // 2 sync + 4 debounce + 1 strobe
    localparam int SW_LAT        = 6;  // 2 sync + 4 debounce
    localparam int BOUNCE_PULSES = 0;
`else
    localparam int LAT           = 3;  // 2 sync + 1 strobe
    localparam int SW_LAT        = 2;
    localparam int BOUNCE_PULSES = 2;  // each one-cycle high passes straight through
`endif

    logic Clock = 1'b0;
    logic Resetn;
    logic sw_raw;
    logic btn_raw;
    logic bit_out;
    logic bit_valid;
    logic sw_level;

    seq_input_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .sw_raw    (sw_raw),
        .btn_raw   (btn_raw),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .sw_level  (sw_level)
    );

    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: channel 0 = switch, channel 1 = button.
    bit hist [2][SYNC];
    bit lvl  [2];
    bit last [2];
    int run  [2];
    bit m_btn_prev, m_out, m_vld;
    int cyc = 0;

    initial begin
        for (int c = 0; c < 2; c++) begin
            lvl[c] = 1'b0; last[c] = 1'b0; run[c] = DEB;
        end
        m_btn_prev = 1'b0; m_out = 1'b0; m_vld = 1'b0;
        forever begin
            @(posedge Clock);
            cyc++;
            if (!Resetn) begin
                for (int c = 0; c < 2; c++) begin
                    for (int s = 0; s < SYNC; s++) hist[c][s] = 1'b0;
                    lvl[c] = 1'b0; last[c] = 1'b0; run[c] = DEB;
                end
                m_btn_prev = 1'b0; m_out = 1'b0; m_vld = 1'b0;
            end else begin
                bit raw;
                bit sv;
                m_vld = lvl[1] && !m_btn_prev;
                if (m_vld) m_out = lvl[0];
                m_btn_prev = lvl[1];
                for (int c = 0; c < 2; c++) begin
                    raw = (c == 0) ? sw_raw : btn_raw;
                    sv  = hist[c][SYNC-1];
                    for (int s = SYNC-1; s > 0; s--) hist[c][s] = hist[c][s-1];
                    hist[c][0] = raw;
`ifdef SEQ_DEBOUNCE_EN
                    // A level is accepted once the synced value has held for DEB samples.
                    if (sv == last[c]) begin
                        if (run[c] < DEB) run[c]++;
                    end else begin
                        last[c] = sv;
                        run[c]  = 1;
                    end
                    if (run[c] >= DEB && sv != lvl[c]) lvl[c] = sv;
`else
                    if (sv == sv) lvl[c] = hist[c][SYNC-1];
`endif
                end
            end
        end
    end

    // Per-cycle comparison plus pulse bookkeeping.
    int n_pulse    = 0;
    bit gap_track  = 1'b0;
    int prev_pulse = -1;
    int min_gap    = 1000;

    initial begin
        forever begin
            @(negedge Clock);
            check("bit_valid", int'(bit_valid), Resetn ? int'(m_vld) : 0);
            check("bit_out", int'(bit_out), Resetn ? int'(m_out) : 0);
            check("sw_level", int'(sw_level), Resetn ? int'(lvl[0]) : 0);
            if (bit_valid) begin
                n_pulse++;
                if (gap_track) begin
                    if (prev_pulse >= 0 && (cyc - prev_pulse) < min_gap)
                        min_gap = cyc - prev_pulse;
                    prev_pulse = cyc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Counts edges until bit_valid is seen; lat stays 0 if the budget expires.
    task automatic wait_valid(input int budget, output int lat, output bit bo);
        lat = 0;
        bo  = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge Clock);
            #1;
            if (bit_valid) begin
                lat = k;
                bo  = bit_out;
                break;
            end
        end
    endtask

    task automatic press(input int hold, input bit exp_bit, input string tag);
        int lat;
        bit bo;
        btn_raw = 1'b1;
        wait_valid(hold, lat, bo);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_bit"}, int'(bo), int'(exp_bit));
        if (hold > lat) tick(hold - lat);
        btn_raw = 1'b0;
    endtask

    initial begin
        int p0;
        int lat;
        bit bo;
        bit [3:0] seq_vals;
        Resetn  = 1'b0;
        sw_raw  = 1'b1;
        btn_raw = 1'b1;

        // Reset with both raw inputs high.
        tick(3);
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_bit_valid", int'(bit_valid), 0);
        check("rst_sw_level", int'(sw_level), 0);
        p0 = n_pulse;
        Resetn = 1'b1;
        wait_valid(40, lat, bo);
        check("rst_release_latency", lat, LAT);
        check("rst_release_bit", int'(bo), 1);
        tick(20);
        check("rst_release_pulses", n_pulse - p0, 1);
        sw_raw  = 1'b0;
        btn_raw = 1'b0;
        tick(15);

        // Clean press with switch low, held 20 cycles.
        p0 = n_pulse;
        press(20, 1'b0, "clean");
        tick(15);
        check("clean_pulses", n_pulse - p0, 1);

        // Short bounce on the button.
        p0 = n_pulse;
        btn_raw = 1'b1; tick(1);
        btn_raw = 1'b0; tick(1);
        btn_raw = 1'b1; tick(1);
        btn_raw = 1'b0;
        tick(20);
        check("bounce_pulses", n_pulse - p0, BOUNCE_PULSES);

        // Sequence feed 0,0,1,1.
        seq_vals   = 4'b1100;
        p0         = n_pulse;
        gap_track  = 1'b1;
        prev_pulse = -1;
        min_gap    = 1000;
        for (int i = 0; i < 4; i++) begin
            sw_raw = seq_vals[i];
            tick(12);
            press(10, seq_vals[i], $sformatf("seq%0d", i));
            tick(8);
        end
        gap_track = 1'b0;
        check("seq_pulses", n_pulse - p0, 4);
        check("seq_min_gap_ge_8", int'(min_gap >= 8), 1);

        // Switch rises in the same cycle the clean button edge becomes visible.
        sw_raw = 1'b0;
        tick(12);
        btn_raw = 1'b1;
        lat = 0;
        bo  = 1'b0;
        p0  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clock);
            #1;
            if (bit_valid && lat == 0) begin
                lat = k;
                bo  = bit_out;
            end
            if (sw_level && p0 == 0) p0 = k - (LAT - 1);
            if (k == LAT - 1) sw_raw = 1'b1;
        end
        check("simul_latency", lat, LAT);
        check("simul_bit", int'(bo), 0);
        check("simul_sw_level_latency", p0, SW_LAT);
        btn_raw = 1'b0;
        tick(15);

        // Reset in the middle of a press; the held button is debounced afresh.
        p0 = n_pulse;
        btn_raw = 1'b1;
        tick(2);
        Resetn = 1'b0;
        tick(2);
        check("midrst_bit_valid", int'(bit_valid), 0);
        Resetn = 1'b1;
        wait_valid(40, lat, bo);
        check("midrst_latency", lat, LAT);
        check("midrst_bit", int'(bo), 1);
        tick(10);
        btn_raw = 1'b0;
        tick(15);
        check("midrst_pulses", n_pulse - p0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
